gs_frame_rx: RTL and testbench

GS_FRAME_RX -- requirements
Module: gs_frame_rx

---
 rtl/gs_pkg.sv | 17 +
 rtl/gs_strobe_delay.sv | 24 ++
 rtl/gs_frame_rx.sv | 105 ++++++++++
 tb/tb_gs_frame_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared types and frame geometry for the game-state frame receiver.
package gs_pkg;

  localparam int FRAME_BYTES = 16;
  localparam int BOARD_W     = 8;
  localparam int BOARD_H     = 16;
  localparam int FRAME_W     = FRAME_BYTES * BOARD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_COMMIT,
    ST_GAP
  } gs_state_e;

endpackage

// File: rtl/gs_strobe_delay.sv
// Delays the read strobe by DATA_LAT cycles so capture lines up with the byte on gs_in.
module gs_strobe_delay #(
  parameter int DATA_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  output logic cap_en_o
);

  logic [DATA_LAT-1:0] dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= strobe_i;
      for (int i = 1; i < DATA_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign cap_en_o = dly_q[DATA_LAT-1];

endmodule

// File: rtl/gs_frame_rx.sv
// Fetches 16-byte game-state frames from the chip into a shadow buffer and
// commits them atomically to a front buffer, single-shot or on a fixed gap.
module gs_frame_rx
  import gs_pkg::*;
#(
  parameter int GAP_CYCLES = 1000,
  parameter int DATA_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               auto_en,
  input  logic [7:0]         gs_in,
  input  logic [3:0]         row_sel,
  output logic               read_gs,
  output logic               busy,
  output logic               frame_valid,
  output logic               frame_changed,
  output logic [15:0]        frame_count,
  output logic [7:0]         row_data,
  output logic [FRAME_W-1:0] frame_out
);

  localparam logic [15:0] GAP_W = 16'(GAP_CYCLES);

  gs_state_e          state_q, state_d;
  logic [3:0]         strb_cnt_q, strb_cnt_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;
  logic [3:0]         cap_idx_q;
  logic [15:0]        frame_count_q;
  logic [FRAME_W-1:0] shadow_q, front_q;
  logic               cap_en;

  gs_strobe_delay #(.DATA_LAT(DATA_LAT)) u_dly (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (read_gs),
    .cap_en_o (cap_en)
  );

  always_comb begin
    state_d    = state_q;
    strb_cnt_d = strb_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    read_gs    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        strb_cnt_d = 4'd0;
        if (start || auto_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        read_gs    = 1'b1;
        strb_cnt_d = strb_cnt_q + 4'd1;
        if (strb_cnt_q == 4'd15) state_d = ST_DRAIN;
      end
      // Wait out the data latency until the last byte lands in the shadow.
      ST_DRAIN: begin
        if (cap_en && cap_idx_q == 4'd15) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        gap_cnt_d = 16'd0;
        if (!auto_en)          state_d = ST_IDLE;
        else if (GAP_W == '0)  state_d = ST_FETCH;
        else                   state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q + 16'd1 == GAP_W) state_d = auto_en ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      strb_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      cap_idx_q     <= '0;
      frame_count_q <= '0;
      shadow_q      <= '0;
      front_q       <= '0;
    end else begin
      state_q    <= state_d;
      strb_cnt_q <= strb_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      if (cap_en) begin
        shadow_q[{cap_idx_q, 3'b000} +: BOARD_W] <= gs_in;
        cap_idx_q                                <= cap_idx_q + 4'd1;
      end
      if (state_q == ST_COMMIT) begin
        front_q       <= shadow_q;
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign frame_valid   = (state_q == ST_COMMIT);
  assign frame_changed = (state_q == ST_COMMIT) && (shadow_q != front_q);
  assign frame_count   = frame_count_q;
  assign frame_out     = front_q;
  assign row_data      = front_q[{row_sel, 3'b000} +: BOARD_W];

endmodule

// File: tb/tb_gs_frame_rx.sv
// Directed bench: two receivers (DATA_LAT=1/GAP=4 and DATA_LAT=3/GAP=0) against a
// transmitter model that returns 8'hA0+idx per sampled strobe.
module tb_gs_frame_rx;

  logic         clk = 1'b0;
  logic         reset;
  logic         start1, auto1, start3, auto3;
  logic [3:0]   rsel1, rsel3;
  logic [7:0]   gs1, gs3;
  logic         read_gs1, busy1, fv1, fc1;
  logic         read_gs3, busy3, fv3, fc3;
  logic [15:0]  cnt1, cnt3;
  logic [7:0]   row1, row3;
  logic [127:0] fo1, fo3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gs_frame_rx #(.GAP_CYCLES(4), .DATA_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .auto_en(auto1), .gs_in(gs1),
    .row_sel(rsel1), .read_gs(read_gs1), .busy(busy1), .frame_valid(fv1),
    .frame_changed(fc1), .frame_count(cnt1), .row_data(row1), .frame_out(fo1)
  );

  gs_frame_rx #(.GAP_CYCLES(0), .DATA_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .auto_en(auto3), .gs_in(gs3),
    .row_sel(rsel3), .read_gs(read_gs3), .busy(busy3), .frame_valid(fv3),
    .frame_changed(fc3), .frame_count(cnt3), .row_data(row3), .frame_out(fo3)
  );

  // Transmitter models; the DATA_LAT=3 one adds two pipeline stages.
  logic [3:0] tx1_idx, tx3_idx;
  logic [7:0] tx1_d, tx3_d, tx3_p1, tx3_p2;

  always @(posedge clk) begin
    if (reset) begin
      tx1_idx <= '0; tx1_d <= '0;
      tx3_idx <= '0; tx3_d <= '0; tx3_p1 <= '0; tx3_p2 <= '0;
    end else begin
      if (read_gs1) begin
        tx1_d   <= 8'hA0 + {4'h0, tx1_idx};
        tx1_idx <= tx1_idx + 4'd1;
      end
      if (read_gs3) begin
        tx3_d   <= 8'hA0 + {4'h0, tx3_idx};
        tx3_idx <= tx3_idx + 4'd1;
      end
      tx3_p1 <= tx3_d;
      tx3_p2 <= tx3_p1;
    end
  end

  assign gs1 = tx1_d;
  assign gs3 = tx3_p2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start (plus optional extra pulse at cycle pulse_at) and watch 40 cycles.
  task automatic run_frame(input bit s3, input int pulse_at, input logic [127:0] exp_front,
                           output int fv_cyc, output int strobes, output logic chg);
    fv_cyc = 0; strobes = 0; chg = 1'bx;
    if (s3) start3 = 1'b1; else start1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1 || k == pulse_at + 1) begin start1 = 1'b0; start3 = 1'b0; end
      if (k == pulse_at) begin if (s3) start3 = 1'b1; else start1 = 1'b1; end
      if (s3 ? read_gs3 : read_gs1) strobes++;
      if ((s3 ? fv3 : fv1) && fv_cyc == 0) begin
        fv_cyc = k;
        chg    = s3 ? fc3 : fc1;
      end
      if (k == 10) begin
        chk("busy_mid_fetch", s3 ? busy3 : busy1, 1'b1);
        chk("front_stable", s3 ? fo3 : fo1, exp_front);
      end
    end
  endtask

  logic [127:0] exp_frame;
  int fv, st, nfv, fvk0, fvk1, fvk2, rise0, rise1;
  logic chg, prev_rg;

  initial begin
    for (int k = 0; k < 16; k++) exp_frame[8*k +: 8] = 8'hA0 + 8'(k);
    reset = 1'b1; start1 = 0; auto1 = 0; start3 = 0; auto3 = 0; rsel1 = 0; rsel3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_read_gs", read_gs1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_fv", fv1, 1'b0);
    chk("rst_count", cnt1, 16'd0);
    chk("rst_front", fo1, 128'd0);
    reset = 1'b0;

    // Single-shot frame, DATA_LAT=1
    run_frame(1'b0, 0, 128'd0, fv, st, chg);
    chk("t1_fv_cycle", fv, 18);
    chk("t1_strobes", st, 16);
    chk("t1_changed", chg, 1'b1);
    chk("t1_count", cnt1, 16'd1);
    rsel1 = 4'd5; #1;
    chk("t1_row5", row1, 8'hA5);
    chk("t1_frame", fo1, exp_frame);

    // Same frame again: unchanged
    run_frame(1'b0, 0, exp_frame, fv, st, chg);
    chk("t2_fv_cycle", fv, 18);
    chk("t2_strobes", st, 16);
    chk("t2_changed", chg, 1'b0);
    chk("t2_count", cnt1, 16'd2);

    // DATA_LAT=3 with start pulsed during FETCH
    run_frame(1'b1, 5, 128'd0, fv, st, chg);
    chk("t3_fv_cycle", fv, 20);
    chk("t3_strobes", st, 16);
    chk("t3_changed", chg, 1'b1);
    chk("t3_count", cnt3, 16'd1);
    chk("t3_frame", fo3, exp_frame);
    rsel3 = 4'd15; #1;
    chk("t3_row15", row3, 8'hAF);

    // Reset at FETCH cycle 7
    start1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
    end
    chk("t4_in_fetch", read_gs1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_read_gs", read_gs1, 1'b0);
    chk("t4_busy", busy1, 1'b0);
    chk("t4_fv", fv1, 1'b0);
    chk("t4_count", cnt1, 16'd0);
    chk("t4_front", fo1, 128'd0);
    run_frame(1'b0, 0, 128'd0, fv, st, chg);
    chk("t4_fv_cycle", fv, 18);
    chk("t4_count_after", cnt1, 16'd1);
    rsel1 = 4'd0; #1;
    chk("t4_row0", row1, 8'hA0);
    chk("t4_frame", fo1, exp_frame);

    // Auto mode, GAP_CYCLES=4: three frames then stop
    st = 0; nfv = 0; fvk0 = 0; fvk1 = 0; fvk2 = 0; rise0 = 0; rise1 = 0; prev_rg = 1'b0;
    auto1 = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (read_gs1) st++;
      if (read_gs1 && !prev_rg) begin
        if (nfv == 1) rise0 = k;
        if (nfv == 2) rise1 = k;
      end
      prev_rg = read_gs1;
      if (fv1) begin
        if (nfv == 0) fvk0 = k;
        if (nfv == 1) fvk1 = k;
        if (nfv == 2) fvk2 = k;
        nfv++;
        if (nfv == 3) auto1 = 1'b0;
      end
    end
    chk("t5_frames", nfv, 3);
    chk("t5_strobes", st, 48);
    chk("t5_fv0", fvk0, 18);
    chk("t5_gap0", rise0 - fvk0, 5);
    chk("t5_gap1", rise1 - fvk1, 5);
    chk("t5_fv2", fvk2, 62);
    chk("t5_count", cnt1, 16'd4);
    chk("t5_idle", busy1, 1'b0);

    // Auto mode, GAP_CYCLES=0: refetch right after COMMIT
    st = 0; nfv = 0; fvk0 = 0;
    auto3 = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (read_gs3) st++;
      if (nfv == 1 && k == fvk0 + 1) begin
        chk("t6_refetch", read_gs3, 1'b1);
        auto3 = 1'b0;
      end
      if (fv3) begin
        nfv++;
        if (nfv == 1) fvk0 = k;
      end
    end
    chk("t6_fv0", fvk0, 20);
    chk("t6_frames", nfv, 2);
    chk("t6_strobes", st, 32);
    chk("t6_count", cnt3, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
